alu_sequencer: RTL and testbench

Instruction sequencer for the ALU datapath. It buffers incoming instruction words in a small FIFO and drives the register-bank/operations handshake for one instruction at a time: operand read (`init`), execution wait (`doneOp`), writeback (`rd`/`doneBr`). It sits between the board-level instruction/enable inputs and the `Operaciones`/`Banco_reg` pair, and adds an optional per-phase watchdog.

---
 rtl/alu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer: FIFO-buffered words driven through READ/EXEC/WRITE handshakes.
// Optional per-phase watchdog with ERR state and sticky error flag under `ALU_SEQ_TIMEOUT_EN.
module alu_sequencer #(
  parameter int TAMINSTR   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active,
  input  logic [TAMINSTR-1:0] instrucciones,
  output logic                ready,
  output logic [TAMINSTR-1:0] instr_cur,
  output logic                init,
  input  logic                doneOp,
  output logic                rd,
  input  logic                doneBr,
  output logic                busy,
  output logic                error,
  output logic [7:0]          count_ops
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
`ifdef ALU_SEQ_TIMEOUT_EN
    S_WRITE,
    S_ERR
`else
    S_WRITE
`endif
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TAMINSTR-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [TAMINSTR-1:0] r_instr_cur;
  logic                r_init;
  logic                r_rd;
  logic [7:0]          r_count_ops;
  logic                w_push;
  logic                w_pop;
  logic                w_timeout;

  assign ready  = (r_count != CW'(FIFO_DEPTH));
  assign w_push = active && ready;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  // Storage is not reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= instrucciones;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_instr_cur <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_instr_cur <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int PW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [PW-1:0] r_phase;
  logic          r_error;

  assign w_timeout = (r_phase == PW'(TIMEOUT - 1));

  // Cleared on every state change, so it restarts on entry to EXEC and WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state != w_next) begin
        r_phase <= '0;
      end else if ((r_state == S_EXEC) || (r_state == S_WRITE)) begin
        r_phase <= r_phase + 1'b1;
      end
      if (w_next == S_ERR) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error = r_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 1);
  assign w_timeout        = 1'b0;
  assign error            = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC: begin
        if (doneOp) begin
          w_next = S_WRITE;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (w_timeout) begin
          w_next = S_ERR;
        end
`endif
      end
      S_WRITE: begin
        if (doneBr) begin
          w_next = S_IDLE;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (w_timeout) begin
          w_next = S_ERR;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_init      <= 1'b0;
      r_rd        <= 1'b0;
      r_count_ops <= '0;
    end else begin
      r_state <= w_next;
      r_init  <= (w_next == S_READ);
      r_rd    <= (w_next == S_WRITE);
      if ((r_state == S_WRITE) && doneBr) begin
        r_count_ops <= r_count_ops + 8'd1;
      end
    end
  end

  assign instr_cur = r_instr_cur;
  assign init      = r_init;
  assign rd        = r_rd;
  assign count_ops = r_count_ops;
  assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer against a transaction-level queue model.
// Compile with +define+ALU_SEQ_TIMEOUT_EN to include the watchdog scenarios.
module tb_alu_sequencer;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       active = 1'b0;
  logic [7:0] instrucciones = '0;
  logic       doneOp = 1'b0;
  logic       doneBr = 1'b0;
  logic       ready, init, rd, busy, error;
  logic [7:0] instr_cur, count_ops;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_timeouts = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_ops = '0;

  alu_sequencer #(.TAMINSTR(8), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .active(active), .instrucciones(instrucciones),
    .ready(ready), .instr_cur(instr_cur), .init(init), .doneOp(doneOp),
    .rd(rd), .doneBr(doneBr), .busy(busy), .error(error), .count_ops(count_ops)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    active = 1'b0; doneOp = 1'b0; doneBr = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    exp_ops = '0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Handshake driver: waits for each init, records the word, answers with random delays.
  task automatic serve(input int n);
    for (int k = 0; k < n; k++) begin
      int cnt;
      cnt = 0;
      while (init !== 1'b1 && cnt < 60) begin
        tick();
        cnt++;
      end
      if (cnt >= 60) begin
        n_timeouts++;
        return;
      end
      obs_q.push_back(instr_cur);
      tick();
      repeat ($urandom_range(0, 3)) tick();
      doneOp = 1'b1;
      tick();
      doneOp = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      doneBr = 1'b1;
      tick();
      doneBr = 1'b0;
      exp_ops = exp_ops + 8'd1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (instr_cur !== 8'h00) begin n_fail++; $display("FAIL reset_instr_cur: got %h want 00", instr_cur); end
    n_checks++; if (init !== 1'b0) begin n_fail++; $display("FAIL reset_init: got %b want 0", init); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", rd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_checks++; if (count_ops !== 8'd0) begin n_fail++; $display("FAIL reset_count_ops: got %0d want 0", count_ops); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    active = 1'b1; instrucciones = 8'hA5;
    tick();
    active = 1'b0;
    n_checks++; if (init !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_pushed: got init=%b busy=%b want init=0 busy=1", init, busy); end
    tick();
    n_checks++; if (init !== 1'b1 || instr_cur !== 8'hA5) begin n_fail++; $display("FAIL single_read: got init=%b instr=%h want init=1 instr=a5", init, instr_cur); end
    tick();
    n_checks++; if (init !== 1'b0 || rd !== 1'b0) begin n_fail++; $display("FAIL single_exec: got init=%b rd=%b want 0 0", init, rd); end
    doneOp = 1'b1;
    tick();
    doneOp = 1'b0;
    n_checks++; if (rd !== 1'b1 || init !== 1'b0) begin n_fail++; $display("FAIL single_write: got rd=%b init=%b want rd=1 init=0", rd, init); end
    tick();
    n_checks++; if (rd !== 1'b1 || count_ops !== 8'd0) begin n_fail++; $display("FAIL single_write_hold: got rd=%b ops=%0d want rd=1 ops=0", rd, count_ops); end
    doneBr = 1'b1;
    tick();
    doneBr = 1'b0;
    exp_ops = exp_ops + 8'd1;
    n_checks++; if (rd !== 1'b0 || count_ops !== exp_ops || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got rd=%b ops=%0d busy=%b want rd=0 ops=%0d busy=0", rd, count_ops, busy, exp_ops); end
    n_checks++; if (instr_cur !== 8'hA5) begin n_fail++; $display("FAIL single_instr_hold: got %h want a5", instr_cur); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 5; i++) begin
      active = 1'b1; instrucciones = w[i];
      tick();
      exp_q.push_back(w[i]);
    end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", ready); end
    n_checks++; if (instr_cur !== w[0]) begin n_fail++; $display("FAIL full_inflight: got %h want %h", instr_cur, w[0]); end
    instrucciones = w[5];
    tick();
    active = 1'b0;
    n_checks++; if (ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL full_drop: got ready=%b busy=%b want 0 1", ready, busy); end
    obs_q.push_back(instr_cur);
    doneOp = 1'b1;
    tick();
    doneOp = 1'b0;
    doneBr = 1'b1;
    tick();
    doneBr = 1'b0;
    exp_ops = exp_ops + 8'd1;
    n_timeouts = 0;
    serve(4);
    repeat (4) tick();
    n_checks++; if (n_timeouts !== 0) begin n_fail++; $display("FAIL full_serve_timeout: got %0d want 0", n_timeouts); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (busy !== 1'b0 || ready !== 1'b1 || count_ops !== exp_ops) begin n_fail++; $display("FAIL full_drain: got busy=%b ready=%b ops=%0d want 0 1 %0d", busy, ready, count_ops, exp_ops); end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] a, b, c;
    int extra;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    active = 1'b1; instrucciones = a;
    tick();
    active = 1'b0;
    tick();
    active = 1'b1; instrucciones = b;
    tick();
    active = 1'b0;
    doneOp = 1'b1;
    tick();
    doneOp = 1'b0;
    doneBr = 1'b1;
    tick();
    doneBr = 1'b0;
    exp_ops = exp_ops + 8'd1;
    active = 1'b1; instrucciones = c;
    tick();
    active = 1'b0;
    n_checks++; if (init !== 1'b1 || instr_cur !== b || ready !== 1'b1) begin n_fail++; $display("FAIL simul_pop: got init=%b instr=%h ready=%b want 1 %h 1", init, instr_cur, ready, b); end
    obs_q.delete();
    n_timeouts = 0;
    serve(2);
    extra = 0;
    repeat (6) begin
      tick();
      if (init === 1'b1) extra++;
    end
    n_checks++; if (n_timeouts !== 0 || obs_q.size() !== 2) begin n_fail++; $display("FAIL simul_count: got %0d words (%0d timeouts) want 2", obs_q.size(), n_timeouts); end
    if (obs_q.size() == 2) begin
      n_checks++; if (obs_q[0] !== b || obs_q[1] !== c) begin n_fail++; $display("FAIL simul_order: got %h %h want %h %h", obs_q[0], obs_q[1], b, c); end
    end
    n_checks++; if (extra !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL simul_dup: got extra_inits=%0d busy=%b want 0 0", extra, busy); end
    n_checks++; if (count_ops !== exp_ops) begin n_fail++; $display("FAIL simul_ops: got %0d want %0d", count_ops, exp_ops); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    exp_q.delete();
    obs_q.delete();
    n_timeouts = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          int cnt;
          logic [7:0] w;
          w = 8'($urandom);
          repeat ($urandom_range(0, 2)) tick();
          cnt = 0;
          while (ready !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
          end
          active = 1'b1; instrucciones = w;
          exp_q.push_back(w);
          tick();
          active = 1'b0;
        end
      end
      serve(N);
    join
    tick();
    n_checks++; if (n_timeouts !== 0 || obs_q.size() !== N) begin n_fail++; $display("FAIL b2b_count: got %0d words (%0d timeouts) want %0d", obs_q.size(), n_timeouts, N); end
    for (int i = 0; i < N && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (count_ops !== exp_ops || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_ops: got ops=%0d busy=%b want %0d 0", count_ops, busy, exp_ops); end
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    logic [7:0] x, y;
    x = 8'($urandom); y = 8'($urandom);
    active = 1'b1; instrucciones = x;
    tick();
    instrucciones = y;
    tick();
    active = 1'b0;
    n_checks++; if (init !== 1'b1 || instr_cur !== x) begin n_fail++; $display("FAIL wd_read: got init=%b instr=%h want 1 %h", init, instr_cur, x); end
    repeat (TO) tick();
    n_checks++; if (error !== 1'b0 || rd !== 1'b0) begin n_fail++; $display("FAIL wd_pre_abort: got error=%b rd=%b want 0 0", error, rd); end
    tick();
    n_checks++; if (error !== 1'b1 || rd !== 1'b0 || init !== 1'b0) begin n_fail++; $display("FAIL wd_err: got error=%b rd=%b init=%b want 1 0 0", error, rd, init); end
    repeat (2) tick();
    n_checks++; if (init !== 1'b1 || instr_cur !== y || count_ops !== exp_ops) begin n_fail++; $display("FAIL wd_next: got init=%b instr=%h ops=%0d want 1 %h %0d", init, instr_cur, count_ops, y, exp_ops); end
    repeat (TO) tick();
    doneOp = 1'b1;
    tick();
    doneOp = 1'b0;
    n_checks++; if (rd !== 1'b1) begin n_fail++; $display("FAIL wd_done_priority: got rd=%b want 1", rd); end
    doneBr = 1'b1;
    tick();
    doneBr = 1'b0;
    exp_ops = exp_ops + 8'd1;
    tick();
    n_checks++; if (count_ops !== exp_ops || error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_sticky: got ops=%0d error=%b busy=%b want %0d 1 0", count_ops, error, busy, exp_ops); end
  endtask
`endif

  task automatic test_reset_mid_write();
    int inits;
    for (int i = 0; i < 3; i++) begin
      active = 1'b1; instrucciones = 8'($urandom);
      tick();
    end
    active = 1'b0;
    doneOp = 1'b1;
    tick();
    doneOp = 1'b0;
    n_checks++; if (rd !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got rd=%b busy=%b want 1 1", rd, busy); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (rd !== 1'b0 || init !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_async: got rd=%b init=%b busy=%b want 0 0 0", rd, init, busy); end
    n_checks++; if (count_ops !== 8'd0 || ready !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL rst_regs: got ops=%0d ready=%b error=%b want 0 1 0", count_ops, ready, error); end
    #1 reset = 1'b1;
    exp_ops = '0;
    inits = 0;
    repeat (5) begin
      tick();
      if (init === 1'b1) inits++;
    end
    n_checks++; if (inits !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_empty: got inits=%0d busy=%b want 0 0", inits, busy); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      int cnt;
      w = 8'(i);
      active = 1'b1; instrucciones = w;
      tick();
      active = 1'b0;
      cnt = 0;
      while (init !== 1'b1 && cnt < 10) begin
        tick();
        cnt++;
      end
      n_checks++; if (init !== 1'b1 || instr_cur !== w) begin n_fail++; $display("FAIL wrap_read[%0d]: got init=%b instr=%h want 1 %h", i, init, instr_cur, w); end
      tick();
      doneBr = 1'b1;
      tick();
      doneBr = 1'b0;
      n_checks++; if (rd !== 1'b0 || count_ops !== exp_ops) begin n_fail++; $display("FAIL wrap_stray[%0d]: got rd=%b ops=%0d want 0 %0d", i, rd, count_ops, exp_ops); end
      doneOp = 1'b1;
      tick();
      doneOp = 1'b0;
      doneBr = 1'b1;
      tick();
      doneBr = 1'b0;
      exp_ops = exp_ops + 8'd1;
      if (i == 254) begin
        n_checks++; if (count_ops !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", count_ops); end
      end
    end
    n_checks++; if (count_ops !== 8'd0 || exp_ops !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", count_ops); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_simul_push_pop();
    test_back_to_back();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_watchdog();
`endif
    test_reset_mid_write();
    test_wrap();
    apply_reset();
    n_checks++; if (count_ops !== 8'd0 || busy !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL final_reset: got ops=%0d busy=%b ready=%b want 0 0 1", count_ops, busy, ready); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
